cache_mem_responder: RTL

- Memory-side responder for the caches_if protocol.
- Serves icache fetch requests (iREN/iaddr, answered with iwait/iload) and dcache read/write requests (dREN/dWEN/daddr/dstore, answered with dwait/dload).
- Arbitrates both requesters onto a single RAM port using the 2-bit ramstate handshake.
- Enforces a per-access timeout and raises a sticky error flag when it expires.
- Sits between the cache pair and the RAM model/bus.

---
 rtl/cache_mem_responder_if.sv | 34 +++
 rtl/cache_mem_responder.sv | 136 +++++++++++++
 2 files changed

// File: rtl/cache_mem_responder_if.sv
// Cache/memory handshake bundle: icache, dcache and RAM port signals.
// slave: the responder side. master: the caches and RAM model side.
interface cache_mem_responder_if;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore,
        input  ramload, ramstate,
        output iwait, iload, dwait, dload,
        output ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore,
        output ramload, ramstate,
        input  iwait, iload, dwait, dload,
        input  ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/cache_mem_responder.sv
// Memory-side responder: arbitrates icache/dcache onto one RAM port.
// Ports: CLK, nRST, bus (slave modport of the cache/RAM bundle), err (sticky timeout).
module cache_mem_responder #(
    parameter int          TIMEOUT  = 64,
    parameter int          CNT_W    = 7,
    parameter logic [31:0] ERR_WORD = 32'hBAD1BAD1
) (
    input  logic                  CLK,
    input  logic                  nRST,
    cache_mem_responder_if.slave  bus,
    output logic                  err
);

    typedef enum logic [1:0] {
        IDLE,
        IACC,
        DACC,
        TURN
    } state_t;

    localparam logic [1:0] RAM_ACCESS = 2'd2;

    state_t             state;
    state_t             next;
    logic [CNT_W-1:0]   cnt;
    logic               last_d;
    logic [31:0]        iload_q;
    logic [31:0]        dload_q;

    logic               access;
    logic               tmo;
    logic               i_done;
    logic               d_done;
    logic               d_rd;
    logic [31:0]        done_word;

    assign access    = (bus.ramstate == RAM_ACCESS);
    assign tmo       = (cnt == CNT_W'(TIMEOUT - 1));
    // A timed-out read returns the error word unless RAM answered that very cycle.
    assign done_word = access ? bus.ramload : ERR_WORD;
    // Writes take priority, so a combined request is treated as a write.
    assign d_rd      = bus.dREN & ~bus.dWEN;

    always_comb begin
        next         = state;
        i_done       = 1'b0;
        d_done       = 1'b0;
        bus.iwait    = 1'b1;
        bus.dwait    = 1'b1;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        unique case (state)
            IDLE: begin
                if (bus.iREN && (bus.dREN || bus.dWEN)) begin
                    next = last_d ? IACC : DACC;
                end else if (bus.iREN) begin
                    next = IACC;
                end else if (bus.dREN || bus.dWEN) begin
                    next = DACC;
                end
            end
            IACC: begin
                if (!bus.iREN) begin
                    next = IDLE;
                end else begin
                    bus.ramREN  = 1'b1;
                    bus.ramaddr = bus.iaddr;
                    if (access || tmo) begin
                        bus.iwait = 1'b0;
                        i_done    = 1'b1;
                        next      = TURN;
                    end
                end
            end
            DACC: begin
                if (!bus.dREN && !bus.dWEN) begin
                    next = IDLE;
                end else begin
                    bus.ramaddr  = bus.daddr;
                    bus.ramstore = bus.dstore;
                    bus.ramWEN   = bus.dWEN;
                    bus.ramREN   = d_rd;
                    if (access || tmo) begin
                        bus.dwait = 1'b0;
                        d_done    = 1'b1;
                        next      = TURN;
                    end
                end
            end
            TURN: begin
                next = IDLE;
            end
            default: begin
                next = IDLE;
            end
        endcase
    end

    assign bus.iload = i_done ? done_word : iload_q;
    assign bus.dload = (d_done && d_rd) ? done_word : dload_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state   <= IDLE;
            cnt     <= '0;
            last_d  <= 1'b0;
            err     <= 1'b0;
            iload_q <= '0;
            dload_q <= '0;
        end else begin
            state <= next;
            // Counter runs only while staying in an access state.
            if ((state == IACC || state == DACC) && next == state) begin
                cnt <= cnt + 1'b1;
            end else begin
                cnt <= '0;
            end
            if (i_done) begin
                last_d  <= 1'b0;
                iload_q <= done_word;
            end
            if (d_done) begin
                last_d <= 1'b1;
                if (d_rd) begin
                    dload_q <= done_word;
                end
            end
            if ((i_done || d_done) && !access) begin
                err <= 1'b1;
            end
        end
    end

endmodule
